// File: rtl/line_memory.sv
// Line-granularity (4 x 32-bit) main memory with a fetch port and a data port.
// The data port has fixed priority, and every access has a fixed latency.
module line_memory #(
    parameter int DEPTH   = 1024,  // 32-bit words, power of two, >= 8
    parameter int LATENCY = 4      // 1..15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req_valid,
    output logic         if_req_ready,
    input  logic [31:0]  if_req_addr,
    output logic         if_resp_valid,
    output logic [127:0] if_resp_data,
    input  logic         dc_req_valid,
    output logic         dc_req_ready,
    input  logic         dc_req_write,
    input  logic [31:0]  dc_req_addr,
    input  logic [127:0] dc_req_wdata,
    output logic         dc_resp_valid,
    output logic [127:0] dc_resp_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW - 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           sel_dc_q;
    logic           wr_q;
    logic [LW-1:0]  line_q;
    logic [127:0]   wdata_q;
    logic [127:0]   if_rdata_q, dc_rdata_q;
    logic [127:0]   rline;
    logic           accept_dc, accept_if, done;

    logic [31:0]    memory [DEPTH];

    assign accept_dc = (state_q == IDLE) && reset && dc_req_valid;
    assign accept_if = (state_q == IDLE) && reset && !dc_req_valid && if_req_valid;
    // done marks the edge E_LATENCY: read sample, write commit, entry to RESP
    assign done      = (state_q == BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Always pass through BUSY, so LATENCY==1 still responds after E1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept_dc || accept_if) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY - 1);
            end
            BUSY: if (cnt_q == 4'd0) state_d = RESP;
                  else               cnt_d   = cnt_q - 4'd1;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dc_req_ready  = (state_q == IDLE) && reset;
        if_req_ready  = (state_q == IDLE) && reset && !dc_req_valid;
        dc_resp_valid = (state_q == RESP) && sel_dc_q;
        if_resp_valid = (state_q == RESP) && !sel_dc_q;
    end

    always_ff @(posedge clk) begin
        if (accept_dc || accept_if) begin
            sel_dc_q <= accept_dc;
            wr_q     <= accept_dc && dc_req_write;
            line_q   <= accept_dc ? dc_req_addr[AW+1:4] : if_req_addr[AW+1:4];
            wdata_q  <= dc_req_wdata;
        end
    end

    always_comb begin
        rline = '0;
        for (int k = 0; k < 4; k++) rline[32*k +: 32] = memory[{line_q, 2'(k)}];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else if (done) begin
            if (sel_dc_q) dc_rdata_q <= wr_q ? wdata_q : rline;
            else          if_rdata_q <= rline;
        end
    end

    always_ff @(posedge clk) begin
        if (done && wr_q)
            for (int k = 0; k < 4; k++) memory[{line_q, 2'(k)}] <= wdata_q[32*k +: 32];
    end

    assign if_resp_data = if_rdata_q;
    assign dc_resp_data = dc_rdata_q;

    logic unused_addr;
    assign unused_addr = ^{if_req_addr[31:AW+2], if_req_addr[3:0],
                           dc_req_addr[31:AW+2], dc_req_addr[3:0]};
endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: unit 0 at LATENCY=4, unit 1 at LATENCY=1.
module tb_line_memory;
    localparam logic [127:0] PROG = 128'hfff10113_001181b3_03200113_03200093;
    localparam logic [127:0] F5   = {4{32'h55555555}};
    localparam logic [127:0] L80  = 128'h24242424_23232323_22222222_21212121;
    localparam logic [127:0] DB   = {4{32'hdeadbeef}};
    localparam logic [127:0] W3   = 128'h0000000d_0000000c_0000000b_0000000a;

    logic clk, reset;
    logic [1:0]         if_v, if_r, if_rv, dc_v, dc_r, dc_w, dc_rv;
    logic [1:0][31:0]   if_a, dc_a;
    logic [1:0][127:0]  dc_wd, if_rd, dc_rd;
    int checks = 0, errors = 0;

    line_memory #(.DEPTH(1024), .LATENCY(4)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_v[0]), .if_req_ready(if_r[0]), .if_req_addr(if_a[0]),
        .if_resp_valid(if_rv[0]), .if_resp_data(if_rd[0]),
        .dc_req_valid(dc_v[0]), .dc_req_ready(dc_r[0]), .dc_req_write(dc_w[0]),
        .dc_req_addr(dc_a[0]), .dc_req_wdata(dc_wd[0]),
        .dc_resp_valid(dc_rv[0]), .dc_resp_data(dc_rd[0]));

    line_memory #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req_valid(if_v[1]), .if_req_ready(if_r[1]), .if_req_addr(if_a[1]),
        .if_resp_valid(if_rv[1]), .if_resp_data(if_rd[1]),
        .dc_req_valid(dc_v[1]), .dc_req_ready(dc_r[1]), .dc_req_write(dc_w[1]),
        .dc_req_addr(dc_a[1]), .dc_req_wdata(dc_wd[1]),
        .dc_resp_valid(dc_rv[1]), .dc_resp_data(dc_rd[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mline(input logic [31:0] addr);
        int b;
        b = int'(addr[11:4]) * 4;
        return {dut.memory[b+3], dut.memory[b+2], dut.memory[b+1], dut.memory[b]};
    endfunction

    typedef struct {
        int           u;
        bit           dc;
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] wd;
        logic [127:0] exp;
        bit           memchk;
        logic [127:0] old;
    } vec_t;

    // Issue one request, then check the response pulse, readies and data cycle by cycle
    task automatic txn(input vec_t v, input string nm);
        int lt;
        lt = (v.u == 1) ? 1 : 4;
        if (v.dc) begin
            dc_v[v.u] = 1'b1; dc_w[v.u] = v.wr; dc_a[v.u] = v.addr; dc_wd[v.u] = v.wd;
        end else begin
            if_v[v.u] = 1'b1; if_a[v.u] = v.addr;
        end
        @(posedge clk); #1;
        dc_v[v.u] = 1'b0; if_v[v.u] = 1'b0; dc_w[v.u] = 1'b0;
        for (int k = 0; k <= lt + 1; k++) begin
            @(negedge clk);
            chk($sformatf("%s rvalid c%0d", nm, k), v.dc ? dc_rv[v.u] : if_rv[v.u], k == lt);
            chk($sformatf("%s other rvalid c%0d", nm, k), v.dc ? if_rv[v.u] : dc_rv[v.u], 0);
            chk($sformatf("%s ready c%0d", nm, k), v.dc ? dc_r[v.u] : if_r[v.u], k == lt + 1);
            if (k == lt) chk({nm, " data"}, v.dc ? dc_rd[v.u] : if_rd[v.u], v.exp);
            if (v.memchk && k == lt - 1) chk({nm, " mem before commit"}, mline(v.addr), v.old);
            if (v.memchk && k == lt)     chk({nm, " mem after commit"}, mline(v.addr), v.wd);
            if (k <= lt) begin @(posedge clk); #1; end
        end
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{0, 1, 1, 32'h0000_0200, PROG, PROG, 0, '0};
        tbl[1]  = '{0, 1, 1, 32'h0000_0040, F5,   F5,   0, '0};
        tbl[2]  = '{0, 1, 1, 32'h0000_0080, L80,  L80,  0, '0};
        tbl[3]  = '{1, 1, 1, 32'h0000_0200, PROG, PROG, 0, '0};
        tbl[4]  = '{0, 0, 0, 32'h0000_0200, '0,   PROG, 0, '0};
        tbl[5]  = '{0, 1, 1, 32'h0000_0040, DB,   DB,   1, F5};
        tbl[6]  = '{0, 1, 0, 32'h0000_0040, '0,   DB,   0, '0};
        tbl[7]  = '{0, 1, 0, 32'h3000_1200, '0,   PROG, 0, '0};
        tbl[8]  = '{1, 0, 0, 32'h1000_0200, '0,   PROG, 0, '0};
        tbl[9]  = '{1, 1, 1, 32'h0000_0ffc, W3,   W3,   0, '0};
        tbl[10] = '{1, 0, 0, 32'h0000_1ff0, '0,   W3,   0, '0};
        tbl[11] = '{0, 0, 0, 32'h0000_020f, '0,   PROG, 0, '0};

        reset = 1'b0;
        if_v = '0; dc_v = '0; dc_w = '0; if_a = '0; dc_a = '0; dc_wd = '0;

        // Outputs while reset is held
        @(negedge clk); @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst u%0d if_ready", u), if_r[u], 0);
            chk($sformatf("rst u%0d dc_ready", u), dc_r[u], 0);
            chk($sformatf("rst u%0d if_rvalid", u), if_rv[u], 0);
            chk($sformatf("rst u%0d dc_rvalid", u), dc_rv[u], 0);
            chk($sformatf("rst u%0d if_rdata", u), if_rd[u], 0);
            chk($sformatf("rst u%0d dc_rdata", u), dc_rd[u], 0);
        end
        reset = 1'b1; #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("post-rst u%0d if_ready", u), if_r[u], 1);
            chk($sformatf("post-rst u%0d dc_ready", u), dc_r[u], 1);
        end

        for (int i = 0; i < 12; i++) txn(tbl[i], $sformatf("vec%0d", i));

        // Simultaneous requests: data port first, fetch taken in the IDLE cycle after RESP
        dc_v[0] = 1'b1; dc_w[0] = 1'b0; dc_a[0] = 32'h40;
        if_v[0] = 1'b1; if_a[0] = 32'h200;
        #1;
        chk("simul if_ready", if_r[0], 0);
        chk("simul dc_ready", dc_r[0], 1);
        @(posedge clk); #1;
        dc_v[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("simul dc_rvalid c%0d", k), dc_rv[0], k == 4);
            chk($sformatf("simul if_rvalid c%0d", k), if_rv[0], k == 10);
            if (k == 4)  chk("simul dc data", dc_rd[0], DB);
            if (k == 5)  chk("simul if_ready idle", if_r[0], 1);
            if (k == 10) chk("simul if data", if_rd[0], PROG);
            @(posedge clk); #1;
            if (k == 5) if_v[0] = 1'b0;
        end

        // Reset two edges into a write: no response and no commit
        dc_v[0] = 1'b1; dc_w[0] = 1'b1; dc_a[0] = 32'h80; dc_wd[0] = {4{32'h11111111}};
        @(posedge clk); #1;
        dc_v[0] = 1'b0; dc_w[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst dc_rvalid", dc_rv[0], 0);
        chk("midrst dc_rdata", dc_rd[0], 0);
        chk("midrst dc_ready", dc_r[0], 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("midrst no resp c%0d", k), dc_rv[0], 0);
        end
        chk("midrst mem unchanged", mline(32'h80), L80);
        chk("midrst idle dc_ready", dc_r[0], 1);
        chk("midrst idle if_ready", if_r[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
